// File: rtl/cpu_fetch_prefetch_pkg.sv
// Shared types for the sequential instruction prefetch queue.
package cpu_fetch_prefetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } prefetch_entry_t;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_REQ  = 1'b1
    } bus_state_t;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/cpu_fetch_prefetch_fifo.sv
// Ring buffer of prefetched {pc, word} entries; flush beats push in the same cycle.
module cpu_prefetch_fifo
    import cpu_fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [63:0]                push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [63:0]                head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    prefetch_entry_t mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Qualify push/pop; fullness and emptiness come from the count, not the pointers.
    always_comb begin
        do_pop_s  = pop && (count_r != '0) && !flush;
        do_push_s = push && !flush && ((count_r != (PW+1)'(DEPTH)) || do_pop_s);
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + {{PW{1'b0}}, do_push_s} - {{PW{1'b0}}, do_pop_s};
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = (count_r != '0);
    assign count      = count_r;

endmodule

// File: rtl/cpu_fetch_prefetch.sv
// Sequential prefetch queue in front of the fetch stage: PC classifier, bus FSM,
// fill address and discard tracking around a small ring buffer.
module cpu_fetch_prefetch
    import cpu_fetch_prefetch_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_input_pc,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_t      state_r;
    logic [31:0]     last_pc_r;
    logic [31:0]     fill_addr_r;
    logic [31:0]     bus_addr_r;
    logic            bus_req_r;
    logic            discard_r;

    logic            seq_s;
    logic            redirect_s;
    logic            push_s;
    logic [63:0]     head_s;
    prefetch_entry_t head_entry_s;
    prefetch_entry_t push_entry_s;
    logic            head_valid_s;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   slots_s;

    // Classify the PC against last cycle's copy and decide whether bus data is kept.
    always_comb begin
        head_entry_s = head_s;
        seq_s        = (i_input_pc == next_word_addr(last_pc_r)) && head_valid_s
                       && (head_entry_s.pc == last_pc_r);
        redirect_s   = (i_input_pc != last_pc_r) && !seq_s;
        push_s       = (state_r == BUS_REQ) && i_bus_ready && !discard_r && !redirect_s;
        push_entry_s = '{pc: bus_addr_r, word: i_bus_rdata};
        slots_s      = count_s + {{(CW-1){1'b0}}, (state_r == BUS_REQ)};
    end

    cpu_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (i_clock),
        .rst_n      (i_reset_n),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (seq_s),
        .flush      (redirect_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    // Bus FSM; a redirect during an outstanding read marks its data for discard.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= BUS_IDLE;
            last_pc_r   <= RESET_VECTOR;
            fill_addr_r <= RESET_VECTOR;
            bus_addr_r  <= RESET_VECTOR;
            bus_req_r   <= 1'b0;
            discard_r   <= 1'b0;
        end else begin
            last_pc_r <= i_input_pc;
            case (state_r)
                BUS_IDLE: begin
                    if (redirect_s) begin
                        fill_addr_r <= i_input_pc;
                    end else if (slots_s < CW'(DEPTH)) begin
                        state_r    <= BUS_REQ;
                        bus_req_r  <= 1'b1;
                        bus_addr_r <= fill_addr_r;
                    end
                end
                BUS_REQ: begin
                    if (i_bus_ready) begin
                        state_r   <= BUS_IDLE;
                        bus_req_r <= 1'b0;
                        discard_r <= 1'b0;
                        if (redirect_s) begin
                            fill_addr_r <= i_input_pc;
                        end else if (!discard_r) begin
                            fill_addr_r <= next_word_addr(fill_addr_r);
                        end
                    end else if (redirect_s) begin
                        discard_r   <= 1'b1;
                        fill_addr_r <= i_input_pc;
                    end
                end
                default: begin
                    state_r   <= BUS_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = head_valid_s && (head_entry_s.pc == i_input_pc);
    assign o_rdata       = head_valid_s ? head_entry_s.word : 32'h0000_0000;
    assign o_bus_request = bus_req_r;
    assign o_bus_address = bus_addr_r;

endmodule

// File: tb/tb_cpu_fetch_prefetch.sv
// Directed bench for cpu_fetch_prefetch with a simple bus slave of programmable latency.
module tb_cpu_fetch_prefetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_bus_request;
    logic        bus_ready;
    logic [31:0] o_bus_address;
    logic [31:0] bus_rdata;

    int          n_checks;
    int          n_errors;
    logic [31:0] addr_log[$];
    int          long_idx;
    int          long_delay;
    int          wait_cnt;
    int          cur_delay;
    logic        slave_en;
    logic        force_ready;
    int          base;
    int          n;

    cpu_fetch_prefetch #(
        .DEPTH        (4),
        .RESET_VECTOR (32'h0000_0100)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_input_pc    (pc),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] log_at(input int idx);
        if (idx >= 0 && idx < addr_log.size()) return addr_log[idx];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    // Bus slave: logs each new request, answers after a per-request latency.
    initial begin
        bus_ready = 1'b0;
        bus_rdata = 32'h0000_0000;
        wait_cnt  = 0;
        cur_delay = 1;
        forever begin
            @(posedge clk);
            #2;
            if (!slave_en) begin
                bus_ready = force_ready;
                bus_rdata = 32'hBAD0_BAD0;
                wait_cnt  = 0;
            end else if (!rst_n || bus_ready) begin
                bus_ready = 1'b0;
                wait_cnt  = 0;
            end else if (o_bus_request) begin
                if (wait_cnt == 0) begin
                    addr_log.push_back(o_bus_address);
                    cur_delay = (addr_log.size() - 1 == long_idx) ? long_delay : 1;
                end
                wait_cnt++;
                if (wait_cnt >= cur_delay) begin
                    bus_ready = 1'b1;
                    bus_rdata = mem_word(o_bus_address);
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        slave_en    = 1'b1;
        force_ready = 1'b0;
        long_idx    = -1;
        long_delay  = 1;
        rst_n       = 1'b0;
        pc          = 32'h0000_0100;

        // Reset state and initial fill of four words
        cycles(2);
        check_eq("rst_req", o_bus_request, 1'b0);
        check_eq("rst_addr", o_bus_address, 32'h0000_0100);
        check_eq("rst_ready", o_ready, 1'b0);
        check_eq("rst_rdata", o_rdata, 32'h0000_0000);
        rst_n = 1'b1;
        cycles(20);
        check_eq("fill_cnt", addr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq("fill_addr", log_at(i), 32'h0000_0100 + 32'(i) * 32'd4);
        check_eq("full_noreq", o_bus_request, 1'b0);
        check_eq("fill_ready", o_ready, 1'b1);
        check_eq("fill_rdata", o_rdata, mem_word(32'h0000_0100));

        // Sequential fetch and refill after first pop
        base = addr_log.size();
        pc = 32'h0000_0104;
        cycles(2);
        check_eq("seq1_ready", o_ready, 1'b1);
        check_eq("seq1_rdata", o_rdata, mem_word(32'h0000_0104));
        check_eq("refill_addr", log_at(base), 32'h0000_0110);
        pc = 32'h0000_0108;
        cycles(2);
        check_eq("seq2_ready", o_ready, 1'b1);
        check_eq("seq2_rdata", o_rdata, mem_word(32'h0000_0108));
        cycles(12);

        // Redirect to 0x2000 while 0x10C is outstanding with a 5-cycle slave
        rst_n = 1'b0;
        pc = 32'h0000_0100;
        cycles(2);
        long_idx   = addr_log.size() + 3;
        long_delay = 5;
        rst_n = 1'b1;
        for (n = 0; n < 40 && !(o_bus_request && o_bus_address == 32'h0000_010C); n++) @(negedge clk);
        check_eq("r1_seen10c", (o_bus_request && o_bus_address == 32'h0000_010C), 1'b1);
        pc = 32'h0000_2000;
        cycles(1);
        check_eq("r1_hold_req", o_bus_request, 1'b1);
        check_eq("r1_hold_addr", o_bus_address, 32'h0000_010C);
        for (n = 0; n < 40 && !(o_bus_request && o_bus_address == 32'h0000_2000 && bus_ready); n++) @(negedge clk);
        check_eq("r1_req2000", (o_bus_request && o_bus_address == 32'h0000_2000 && bus_ready), 1'b1);
        check_eq("r1_next_addr", log_at(long_idx + 1), 32'h0000_2000);
        check_eq("r1_not_yet", o_ready, 1'b0);
        cycles(1);
        check_eq("r1_ready", o_ready, 1'b1);
        check_eq("r1_rdata", o_rdata, mem_word(32'h0000_2000));
        cycles(12);

        // Two redirects during one outstanding request
        long_idx   = addr_log.size();
        long_delay = 8;
        pc = 32'h0000_1000;
        for (n = 0; n < 20 && !(addr_log.size() > long_idx); n++) @(negedge clk);
        check_eq("r2_req1000", log_at(long_idx), 32'h0000_1000);
        pc = 32'h0000_0300;
        cycles(1);
        pc = 32'h0000_0400;
        for (n = 0; n < 40 && !o_ready; n++) @(negedge clk);
        check_eq("r2_ready", o_ready, 1'b1);
        check_eq("r2_rdata", o_rdata, mem_word(32'h0000_0400));
        check_eq("r2_next_addr", log_at(long_idx + 1), 32'h0000_0400);
        cycles(12);

        // Address wrap past 0xFFFFFFFC
        base = addr_log.size();
        pc = 32'hFFFF_FFF8;
        cycles(12);
        check_eq("wrap_cnt", addr_log.size(), base + 4);
        check_eq("wrap_a0", log_at(base), 32'hFFFF_FFF8);
        check_eq("wrap_a1", log_at(base + 1), 32'hFFFF_FFFC);
        check_eq("wrap_a2", log_at(base + 2), 32'h0000_0000);
        check_eq("wrap_a3", log_at(base + 3), 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            check_eq("wrap_ready", o_ready, 1'b1);
            check_eq("wrap_rdata", o_rdata, mem_word(pc));
            pc = pc + 32'd4;
            cycles(2);
        end
        cycles(12);

        // Reset in the middle of an outstanding request, stale ready afterwards
        long_idx   = addr_log.size();
        long_delay = 8;
        pc = 32'h0000_5000;
        for (n = 0; n < 20 && !(addr_log.size() > long_idx); n++) @(negedge clk);
        check_eq("mr_req5000", o_bus_address, 32'h0000_5000);
        slave_en    = 1'b0;
        force_ready = 1'b1;
        rst_n       = 1'b0;
        pc          = 32'h0000_0100;
        #1;
        check_eq("mr_req_drop", o_bus_request, 1'b0);
        check_eq("mr_addr", o_bus_address, 32'h0000_0100);
        check_eq("mr_ready", o_ready, 1'b0);
        cycles(2);
        rst_n       = 1'b1;
        force_ready = 1'b0;
        cycles(1);
        check_eq("mr_new_req", o_bus_request, 1'b1);
        check_eq("mr_new_addr", o_bus_address, 32'h0000_0100);
        check_eq("mr_stale_ign", o_ready, 1'b0);
        cycles(1);
        check_eq("mr_stale_ign2", o_ready, 1'b0);
        long_idx = -1;
        slave_en = 1'b1;
        for (n = 0; n < 20 && !o_ready; n++) @(negedge clk);
        check_eq("mr_ready_after", o_ready, 1'b1);
        check_eq("mr_rdata", o_rdata, mem_word(32'h0000_0100));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
